// File: rtl/skid_buffer_async_rstn.sv
// -----------------------------------------------------------------------------
// skid_buffer_async_rstn
//
// Two-entry valid/ready pipeline stage with full throughput. Every output,
// s_ready included, comes straight from a flop, so this stage breaks
// combinational paths in both the forward (valid/data) and backward (ready)
// directions.
//
// The main register drives m_data. The skid register catches the one beat
// that can arrive in the cycle after downstream stalls, because s_ready is
// registered and can only fall one cycle late.
//
// Ports
//   clk      in   1      rising-edge clock
//   rstn     in   1      asynchronous active-low reset
//   s_valid  in   1      upstream beat present on s_data
//   s_ready  out  1      stage can accept a beat (registered)
//   s_data   in   WIDTH  upstream payload
//   m_valid  out  1      m_data holds a valid beat (registered)
//   m_ready  in   1      downstream accepts the beat this cycle
//   m_data   out  WIDTH  downstream payload (registered, = main register)
// -----------------------------------------------------------------------------
module skid_buffer_async_rstn #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    // Occupancy: EMPTY = no beats, BUSY = one beat in main, FULL = main + skid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             s_ready_q;
    logic             m_valid_q;

    // Handshakes as seen at the coming rising edge.
    logic xfer_in;
    logic xfer_out;

    assign xfer_in  = s_valid & s_ready_q;
    assign xfer_out = m_valid_q & m_ready;

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = main_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= EMPTY;
            // NOTE: the payload registers are reset as well, so m_data reads
            // 0 after reset and no stale beat survives a mid-stream reset.
            main_q    <= '0;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge values of state and the handshake flags.
            case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        main_q    <= s_data;
                        state     <= BUSY;
                        m_valid_q <= 1'b1;
                    end
                end

                BUSY: begin
                    if (xfer_in && xfer_out) begin
                        // Streaming: replace the departing beat in place.
                        main_q <= s_data;
                    end else if (xfer_in) begin
                        // Downstream stalled; park the new beat in skid.
                        skid_q    <= s_data;
                        state     <= FULL;
                        s_ready_q <= 1'b0;
                    end else if (xfer_out) begin
                        // main_q keeps its last value; only valid drops.
                        state     <= EMPTY;
                        m_valid_q <= 1'b0;
                    end
                end

                FULL: begin
                    // No input can arrive here because s_ready is low.
                    if (xfer_out) begin
                        main_q    <= skid_q;
                        state     <= BUSY;
                        s_ready_q <= 1'b1;
                    end
                end

                default: begin
                    // Illegal encoding 2'b11: recover to a clean empty stage.
                    state     <= EMPTY;
                    m_valid_q <= 1'b0;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skid_buffer_async_rstn.sv
// -----------------------------------------------------------------------------
// tb_skid_buffer_async_rstn
//
// Directed bench for skid_buffer_async_rstn (WIDTH = 8). Inputs are driven
// 1 time unit after each rising edge and outputs are sampled at the same
// point, so every check sees the state produced by the edge just taken.
// -----------------------------------------------------------------------------
module tb_skid_buffer_async_rstn;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rstn;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    int tests_run = 0;
    int tests_failed = 0;

    skid_buffer_async_rstn #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net: the directed sequence is short, so this should never fire.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic exp_mv,
                             input logic exp_sr, input logic [7:0] exp_md);
        check({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, exp_mv});
        check({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, exp_sr});
        check({tag, ".m_data"},  {24'd0, m_data},  {24'd0, exp_md});
    endtask

    // Stall-pattern tables (hand-computed, see comments in the sequence).
    logic       stall_rdy [8];
    logic       stall_vld [8];
    logic [7:0] stall_dat [8];
    logic       stall_mv  [8];
    logic       stall_sr  [8];
    logic [7:0] stall_md  [8];

    initial begin
        rstn    = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // ---------------- Reset values ----------------
        step();
        step();
        check_out("por", 1'b0, 1'b1, 8'h00);
        rstn = 1'b1;

        // Load a stale beat that the next reset must wipe.
        s_valid = 1'b1;
        s_data  = 8'h5A;
        step();
        s_valid = 1'b0;
        check_out("stale_load", 1'b1, 1'b1, 8'h5A);

        // Mid-cycle async reset: outputs clear without a clock edge.
        #3;
        rstn = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b1, 8'h00);
        step();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_out("idle_after_rst", 1'b0, 1'b1, 8'h00);
        end

        // ---------------- Single beat ----------------
        s_valid = 1'b1;
        s_data  = 8'hA5;
        m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        check_out("single_load", 1'b1, 1'b1, 8'hA5);
        step();
        // Consumed; main_q keeps its last value.
        check_out("single_drain", 1'b0, 1'b1, 8'hA5);

        // ---------------- Streaming 0x00..0x0F ----------------
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i);
            m_ready = 1'b1;
            step();
            check_out("stream", 1'b1, 1'b1, 8'(i));
        end
        s_valid = 1'b0;
        step();
        check_out("stream_end", 1'b0, 1'b1, 8'h0F);

        // ---------------- Backpressure fill and drain ----------------
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h10;
        step();                                  // EMPTY -> BUSY(10)
        check_out("bp_10", 1'b1, 1'b1, 8'h10);
        s_data = 8'h11;
        step();                                  // BUSY -> FULL, skid=11
        check_out("bp_11", 1'b1, 1'b0, 8'h10);
        s_data = 8'h12;
        step();                                  // FULL hold, 12 waits
        check_out("bp_hold", 1'b1, 1'b0, 8'h10);
        m_ready = 1'b1;
        step();                                  // 10 out, main=11
        check_out("bp_drain11", 1'b1, 1'b1, 8'h11);
        step();                                  // 11 out, 12 in
        check_out("bp_drain12", 1'b1, 1'b1, 8'h12);
        s_valid = 1'b0;
        step();                                  // 12 out -> EMPTY
        check_out("bp_empty", 1'b0, 1'b1, 8'h12);

        // ---------------- Stability under stall ----------------
        // ready 1,0,0,1,0,1 then 1,1. Upstream holds its beat until accepted.
        // c0 in 40            -> BUSY m=40 sr=1
        // c1 in 41, stall     -> FULL m=40 sr=0
        // c2 stall            -> FULL m=40 sr=0 (42 waits)
        // c3 out 40           -> BUSY m=41 sr=1 (42 not taken, sr was 0)
        // c4 in 42, stall     -> FULL m=41 sr=0
        // c5 out 41           -> BUSY m=42 sr=1 (43 not taken)
        // c6 in 43, out 42    -> BUSY m=43 sr=1
        // c7 out 43           -> EMPTY m=43
        stall_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        stall_vld = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        stall_dat = '{8'h40, 8'h41, 8'h42, 8'h42, 8'h42, 8'h43, 8'h43, 8'h00};
        stall_mv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        stall_sr  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        stall_md  = '{8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h42, 8'h43, 8'h43};
        for (int c = 0; c < 8; c++) begin
            m_ready = stall_rdy[c];
            s_valid = stall_vld[c];
            s_data  = stall_dat[c];
            step();
            check_out("stall", stall_mv[c], stall_sr[c], stall_md[c]);
        end

        // ---------------- Reset in FULL ----------------
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h20;
        step();
        s_data = 8'h21;
        step();
        check_out("full_pre_rst", 1'b1, 1'b0, 8'h20);
        s_valid = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        check_out("full_async_rst", 1'b0, 1'b1, 8'h00);
        step();
        rstn = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h30;
        m_ready = 1'b1;
        step();                                  // first edge after release
        s_valid = 1'b0;
        check_out("post_rst_30", 1'b1, 1'b1, 8'h30);
        step();
        // Skid contents (0x21) must not reappear after 0x30 drains.
        check_out("post_rst_empty", 1'b0, 1'b1, 8'h30);
        step();
        check_out("post_rst_idle", 1'b0, 1'b1, 8'h30);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/skid_buffer_async_rstn.md
# skid_buffer_async_rstn

Two-entry valid/ready pipeline stage with full throughput and registered outputs in both directions. It sits directly upstream of an enable register in a datapath. Its `m_valid & m_ready` handshake is the register's `en`, and `m_data` is its `din`. Every output, including `s_ready`, is registered, so the block breaks combinational timing paths in both the forward and backward directions.

## Interface
- `WIDTH`, default 8: payload width in bits; legal range 1 and above.
- `clk`  input  1  clock; all logic is rising-edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `s_valid`  input  1  upstream has a beat on `s_data`.
- `s_ready`  output  1  block can accept a beat; registered.
- `s_data`  input  WIDTH  upstream payload.
- `m_valid`  output  1  `m_data` holds a valid beat; registered.
- `m_ready`  input  1  downstream accepts the beat this cycle.
- `m_data`  output  WIDTH  downstream payload; registered.

## Operation
- **Handshake rules**
  - A beat transfers on a rising edge where valid and ready are both 1, on either side.
  - Upstream may hold `s_valid` regardless of `s_ready`.
  - `s_valid` does not depend on `s_ready`, and `m_valid` does not depend on `m_ready`.
- **Storage**
  - Main register `main_q`, which drives `m_data`.
  - Skid register `skid_q`, which is internal.
  - State encodes occupancy: EMPTY (0 entries), BUSY (1, in main), FULL (2, main plus skid).
- **Registered outputs**
  - `m_valid = (state != EMPTY)`.
  - `s_ready = (state != FULL)`.
  - Both are registered flops updated alongside the state, not decoded from it combinationally.
- **Transitions** (`in = s_valid & s_ready`, `out = m_valid & m_ready`)
  - EMPTY, `in`: `main_q <= s_data`; go to BUSY.
  - EMPTY, no `in`: hold.
  - BUSY, `in & out`: `main_q <= s_data`; stay BUSY (streaming).
  - BUSY, `in & !out`: `skid_q <= s_data`; go to FULL; `s_ready <= 0`.
  - BUSY, `!in & out`: go to EMPTY; `main_q` is not cleared.
  - BUSY, `!in & !out`: hold.
  - FULL, `out`: `main_q <= skid_q`; go to BUSY; `s_ready <= 1`.
  - FULL, no `out`: hold. `in` cannot occur because `s_ready` is 0.
  - The state encoding 2'b11 is illegal and recovers to EMPTY with `s_ready = 1` and `m_valid = 0`.
- **Data integrity**
  - Beats leave in arrival order. None are dropped or duplicated.
  - While `m_valid = 1` and `m_ready = 0`, `m_data` is held stable.
  - `m_data` while `m_valid = 0` is don't-care for consumers, but it always equals the last value loaded into `main_q`.
- **Reset values** (asserted immediately on `rstn` low, independent of `clk`)
  - State: EMPTY.
  - `m_valid = 0`, `s_ready = 1`.
  - `main_q = 0`, so `m_data = 0`.
  - `skid_q = 0`.
- **Reset mid-operation:** any buffered beats are discarded. The first accepted beat after reset release is the next `m_data`.

## Timing
- Latency: a beat accepted at edge N appears on `m_data` with `m_valid = 1` after edge N, and is available for consumption at edge N+1.
- Throughput: 1 beat/cycle sustained when `m_ready` is held at 1.
- Backpressure: `s_ready` falls one cycle after the first cycle `m_ready` is low with a beat in flight. The skid register absorbs the single beat accepted in that cycle.
- Recovery: `s_ready` rises on the edge after `m_ready` returns high in FULL, so at most 1 bubble appears upstream.
- `rstn` deassertion must be synchronous to `clk`, which is handled by the reset synchronizer outside this block. With `s_valid = 1`, the first transfer occurs on the first edge after release.

## Test plan
- **Reset values:** assert `rstn = 0` mid-cycle with stale contents present -> immediately `m_valid = 0`, `s_ready = 1`, `m_data = 0`. After release with no input, these remain stable for 10 cycles.
- **Single beat:** drive `s_data = 0xA5` for one handshake with `m_ready = 1` -> `m_valid = 1`, `m_data = 0xA5` after the edge. The beat is consumed next edge, then `m_valid = 0`.
- **Streaming:** drive 16 back-to-back beats 0x00..0x0F with `m_ready = 1` -> `s_ready` stays 1 throughout, and the output sequence 0x00..0x0F appears on consecutive cycles with 1-cycle latency.
- **Backpressure fill and drain:** stream 0x10, 0x11, 0x12 with `m_ready = 0` from the start ->
  - 0x10 is held on `m_data`; 0x11 is captured in skid; `s_ready = 0` on the cycle after 0x11 is accepted; 0x12 waits upstream.
  - Then raise `m_ready`: the output order is 0x10, 0x11, 0x12 with no loss.
- **Stability under stall:** toggle `m_ready` 1,0,0,1,0,1 while streaming an incrementing pattern -> `m_data` never changes while `m_valid & !m_ready`, every value appears exactly once, and the sequence stays ordered.
- **Reset in FULL:** reach FULL with 0x20 and 0x21 buffered, then pulse `rstn` low ->
  - `m_valid = 0` and `s_ready = 1` immediately.
  - After release, beat 0x30 is the next output; 0x20 and 0x21 never appear.
